// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-set controller.
// Holds the FSM state enum, field indices and parameter defaults.
package rtc_pkg;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StSetIdle   = 2'd1,
        StSetHold   = 2'd2,
        StSetRepeat = 2'd3
    } set_state_e;

    localparam int unsigned SEC = 0;
    localparam int unsigned MIN = 1;
    localparam int unsigned HR  = 2;

    localparam int unsigned SampleDivDef = 49999;
    localparam int unsigned DebDepthDef  = 8;
    localparam int unsigned RepeatDlyDef = 500;
    localparam int unsigned RepeatPerDef = 100;

    // Hours beat minutes beat seconds when presses land together.
    function automatic logic [1:0] field_sel(logic [2:0] press);
        if (press[HR]) begin
            return 2'(HR);
        end else if (press[MIN]) begin
            return 2'(MIN);
        end
        return 2'(SEC);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a sample-tick debouncer; the output level
// changes only after DEB_DEPTH consecutive samples disagree with it.
module button_debouncer
    import rtc_pkg::*;
#(
    parameter int unsigned DEB_DEPTH = DebDepthDef
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic sample_tick,
    output logic level
);

    localparam int unsigned CntW = $clog2(DEB_DEPTH + 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sample_tick) begin
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntW'(DEB_DEPTH - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/rtc_set_ctrl.sv
// Manual time-set controller: debounces three field buttons, runs the set FSM
// with hold-to-repeat, and drives registered increment/clear/blink strobes.
module rtc_set_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = SampleDivDef,
    parameter int unsigned DEB_DEPTH  = DebDepthDef,
    parameter int unsigned REPEAT_DLY = RepeatDlyDef,
    parameter int unsigned REPEAT_PER = RepeatPerDef
) (
    input  logic       clock50MHz,
    input  logic       resetn,
    input  logic [2:0] push_button,
    input  logic       man_switch,
    input  logic       tick_1hz,
    output logic       run_en,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hr,
    output logic       clr_sec,
    output logic       blink,
    output logic [1:0] set_state
);

    localparam int unsigned DivW   = $clog2(SAMPLE_DIV + 2);
    localparam int unsigned RepMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    logic [DivW-1:0] div_q;
    logic            sample_tick;
    logic            man_s1_q, man_s2_q;
    logic [2:0]      level, level_prev_q, press;
    logic            active_rel;
    set_state_e      state_q, state_d;
    logic [1:0]      active_q, active_d;
    logic [RepW-1:0] rep_q, rep_d;
    logic            fire;
    logic [2:0]      inc_q, inc_d;
    logic            clr_q, clr_d, run_en_q, run_en_d, blink_q, blink_d;

    assign sample_tick = (div_q == DivW'(SAMPLE_DIV));

    button_debouncer #(.DEB_DEPTH(DEB_DEPTH)) u_deb_sec (
        .clk(clock50MHz), .rst_n(resetn), .raw(push_button[SEC]),
        .sample_tick(sample_tick), .level(level[SEC])
    );
    button_debouncer #(.DEB_DEPTH(DEB_DEPTH)) u_deb_min (
        .clk(clock50MHz), .rst_n(resetn), .raw(push_button[MIN]),
        .sample_tick(sample_tick), .level(level[MIN])
    );
    button_debouncer #(.DEB_DEPTH(DEB_DEPTH)) u_deb_hr (
        .clk(clock50MHz), .rst_n(resetn), .raw(push_button[HR]),
        .sample_tick(sample_tick), .level(level[HR])
    );

    // Buttons are active-low, so a press is a debounced 1->0 edge.
    assign press = level_prev_q & ~level;
    assign active_rel = (active_q == 2'(HR))  ? level[HR]  :
                        (active_q == 2'(MIN)) ? level[MIN] : level[SEC];

    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) begin
            div_q        <= '0;
            man_s1_q     <= 1'b0;
            man_s2_q     <= 1'b0;
            level_prev_q <= 3'b111;
            state_q      <= StRun;
            active_q     <= 2'(SEC);
            rep_q        <= '0;
            inc_q        <= 3'b000;
            clr_q        <= 1'b0;
            run_en_q     <= 1'b1;
            blink_q      <= 1'b1;
        end else begin
            div_q        <= sample_tick ? '0 : div_q + DivW'(1);
            man_s1_q     <= man_switch;
            man_s2_q     <= man_s1_q;
            level_prev_q <= level;
            state_q      <= state_d;
            active_q     <= active_d;
            rep_q        <= rep_d;
            inc_q        <= inc_d;
            clr_q        <= clr_d;
            run_en_q     <= run_en_d;
            blink_q      <= blink_d;
        end
    end

    // Leaving set mode outranks every other transition in the set states.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        rep_d    = rep_q;
        fire     = 1'b0;
        case (state_q)
            StRun: begin
                if (man_s2_q) state_d = StSetIdle;
            end
            StSetIdle: begin
                if (!man_s2_q) begin
                    state_d = StRun;
                end else if (|press) begin
                    active_d = field_sel(press);
                    rep_d    = '0;
                    fire     = 1'b1;
                    state_d  = StSetHold;
                end
            end
            StSetHold: begin
                if (!man_s2_q) begin
                    state_d = StRun;
                end else if (active_rel) begin
                    state_d = StSetIdle;
                end else if (sample_tick) begin
                    if (rep_q == RepW'(REPEAT_DLY - 1)) begin
                        rep_d   = '0;
                        fire    = 1'b1;
                        state_d = StSetRepeat;
                    end else begin
                        rep_d = rep_q + RepW'(1);
                    end
                end
            end
            StSetRepeat: begin
                if (!man_s2_q) begin
                    state_d = StRun;
                end else if (active_rel) begin
                    state_d = StSetIdle;
                end else if (sample_tick) begin
                    if (rep_q == RepW'(REPEAT_PER - 1)) begin
                        rep_d = '0;
                        fire  = 1'b1;
                    end else begin
                        rep_d = rep_q + RepW'(1);
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        inc_d    = fire ? (3'b001 << active_d) : 3'b000;
        clr_d    = (state_q == StRun) && (state_d == StSetIdle);
        run_en_d = (state_d == StRun);
        if (state_d == StRun || state_q == StRun) begin
            blink_d = 1'b1;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
    end

    assign inc_sec   = inc_q[SEC];
    assign inc_min   = inc_q[MIN];
    assign inc_hr    = inc_q[HR];
    assign clr_sec   = clr_q;
    assign run_en    = run_en_q;
    assign blink     = blink_q;
    assign set_state = state_q;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Self-checking bench for rtc_set_ctrl: directed scenarios plus random button
// traffic, every cycle compared against a behavioural model of the set rules.
module tb_rtc_set_ctrl;

    localparam int SD = 9;
    localparam int DD = 4;
    localparam int RD = 5;
    localparam int RP = 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] push_button;
    logic       man_switch;
    logic       tick_1hz;
    logic       run_en, inc_sec, inc_min, inc_hr, clr_sec, blink;
    logic [1:0] set_state;

    always #5 clk = ~clk;

    rtc_set_ctrl #(
        .SAMPLE_DIV(SD), .DEB_DEPTH(DD), .REPEAT_DLY(RD), .REPEAT_PER(RP)
    ) dut (
        .clock50MHz(clk), .resetn(resetn), .push_button(push_button),
        .man_switch(man_switch), .tick_1hz(tick_1hz), .run_en(run_en),
        .inc_sec(inc_sec), .inc_min(inc_min), .inc_hr(inc_hr), .clr_sec(clr_sec),
        .blink(blink), .set_state(set_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_sec, n_min, n_hr, n_clr;
    int sec_times[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Behavioural model: mode 0 run, 1 idle, 2 holding, 3 repeating.
    int         m_mode, m_act, m_held, m_cnt;
    bit         m_man1, m_man2;
    bit [2:0]   m_bs1, m_bs2, m_lev, m_prv;
    bit         m_hist[3][DD];
    bit         e_run, e_clr, e_blink;
    bit [2:0]   e_inc;
    logic [1:0] e_state;

    task automatic model_reset();
        m_mode = 0; m_act = 0; m_held = 0; m_cnt = 0;
        m_man1 = 0; m_man2 = 0;
        m_bs1 = 3'b111; m_bs2 = 3'b111; m_lev = 3'b111; m_prv = 3'b111;
        for (int b = 0; b < 3; b++) for (int k = 0; k < DD; k++) m_hist[b][k] = 1'b1;
        e_run = 1; e_clr = 0; e_blink = 1; e_inc = 3'b000; e_state = 2'd0;
    endtask

    task automatic model_step();
        bit       tick, man, agree;
        bit [2:0] lev_old, prv_old, press;
        int       old_mode;
        tick    = ((m_cnt % (SD + 1)) == SD);
        m_cnt++;
        man     = m_man2;
        lev_old = m_lev;
        prv_old = m_prv;
        if (tick) begin
            for (int b = 0; b < 3; b++) begin
                for (int k = DD - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
                m_hist[b][0] = m_bs2[b];
                agree = 1;
                for (int k = 1; k < DD; k++) if (m_hist[b][k] != m_hist[b][0]) agree = 0;
                if (agree) m_lev[b] = m_hist[b][0];
            end
        end
        m_prv  = lev_old;
        m_man2 = m_man1; m_man1 = man_switch;
        m_bs2  = m_bs1;  m_bs1  = push_button;

        press    = prv_old & ~lev_old;
        e_inc    = 3'b000;
        e_clr    = 0;
        old_mode = m_mode;
        if (m_mode == 0) begin
            if (man) begin m_mode = 1; e_clr = 1; end
        end else if (!man) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (press != 0) begin
                m_act = press[2] ? 2 : (press[1] ? 1 : 0);
                e_inc[m_act] = 1;
                m_mode = 2;
                m_held = 0;
            end
        end else if (lev_old[m_act]) begin
            m_mode = 1;
        end else if (tick) begin
            m_held++;
            if (m_held == RD) begin
                m_mode = 3;
                e_inc[m_act] = 1;
            end else if (m_held > RD && ((m_held - RD) % RP) == 0) begin
                e_inc[m_act] = 1;
            end
        end
        e_run   = (m_mode == 0);
        e_state = 2'(m_mode);
        if (m_mode == 0 || old_mode == 0) e_blink = 1;
        else if (tick_1hz) e_blink = ~e_blink;
    endtask

    task automatic step();
        @(posedge clk);
        if (!resetn) model_reset();
        else model_step();
        #1;
        cyc++;
        check_eq("outputs", {run_en, inc_hr, inc_min, inc_sec, clr_sec, blink, set_state},
                 {e_run, e_inc, e_clr, e_blink, e_state});
        check_eq("strobe_onehot", ($countones({inc_hr, inc_min, inc_sec, clr_sec}) <= 1), 1);
        n_sec += inc_sec; n_min += inc_min; n_hr += inc_hr; n_clr += clr_sec;
        if (inc_sec) sec_times.push_back(cyc);
        tick_1hz = ($urandom_range(0, 15) == 0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        n_sec = 0; n_min = 0; n_hr = 0; n_clr = 0;
        sec_times.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        resetn = 0; push_button = 3'b111; man_switch = 0; tick_1hz = 0;
        model_reset();
        clear_counts();
        run(3);
        check_eq("reset_run_en", run_en, 1);
        check_eq("reset_blink", blink, 1);
        check_eq("reset_state", set_state, 0);
        check_eq("reset_strobes", {inc_hr, inc_min, inc_sec, clr_sec}, 0);
        resetn = 1;

        // Button noise in run mode must never produce strobes.
        repeat (100) begin push_button = 3'($urandom); step(); end
        push_button = 3'b111;
        run(60);
        check_eq("run_no_strobes", n_sec + n_min + n_hr + n_clr, 0);

        clear_counts();
        man_switch = 1;
        run(2);
        check_eq("man_sync_delay", set_state, 0);
        step();
        check_eq("enter_set_state", set_state, 1);
        check_eq("enter_clr_sec", clr_sec, 1);
        check_eq("enter_run_en", run_en, 0);
        run(20);
        check_eq("clr_sec_once", n_clr, 1);

        // Short press: below the repeat delay, so only the accept strobe.
        clear_counts();
        push_button[1] = 0; run(40);
        push_button = 3'b111; run(80);
        check_eq("min_press_count", n_min, 1);
        check_eq("min_press_other", n_sec + n_hr, 0);
        clear_counts();
        push_button[1] = 0; run(25);
        push_button = 3'b111; run(80);
        check_eq("glitch_ignored", n_min + n_sec + n_hr, 0);

        // Long hold: accept, repeat after RD samples, then every RP samples.
        clear_counts();
        push_button[0] = 0; run(200);
        push_button = 3'b111; run(80);
        check_eq("hold_sec_count", n_sec, 9);
        check_eq("repeat_period_a", sec_times[2] - sec_times[1], 20);
        check_eq("repeat_period_b", sec_times[8] - sec_times[7], 20);

        clear_counts();
        push_button = 3'b010; run(40);
        push_button = 3'b111; run(80);
        check_eq("prio_hr_count", n_hr, 1);
        check_eq("prio_no_sec", n_sec, 0);

        clear_counts();
        push_button[0] = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin step(); if (set_state == 2'd3) seen = 1; end
        check_eq("reach_repeat", seen, 1);
        man_switch = 0;
        run(3);
        check_eq("exit_state", set_state, 0);
        check_eq("exit_run_en", run_en, 1);
        clear_counts();
        run(100);
        push_button = 3'b111; run(60);
        check_eq("exit_no_strobes", n_sec + n_min + n_hr + n_clr, 0);

        man_switch = 1; run(30);
        push_button = 3'b011;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin step(); if (set_state == 2'd2) seen = 1; end
        check_eq("reach_hold", seen, 1);
        #2;
        resetn = 0;
        #1;
        check_eq("async_run_en", run_en, 1);
        check_eq("async_blink", blink, 1);
        check_eq("async_state", set_state, 0);
        check_eq("async_strobes", {inc_hr, inc_min, inc_sec, clr_sec}, 0);
        push_button = 3'b111; man_switch = 0;
        run(2);
        resetn = 1;
        clear_counts();
        run(100);
        check_eq("post_reset_strobes", n_sec + n_min + n_hr + n_clr, 0);
        check_eq("post_reset_state", set_state, 0);

        // Random episodes, checked cycle by cycle against the model.
        repeat (40) begin
            man_switch  = ($urandom_range(0, 5) != 0);
            push_button = 3'($urandom);
            run($urandom_range(5, 250));
            push_button = 3'b111;
            run($urandom_range(10, 120));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
